brush_ctrl: RTL and testbench
=============================

// Module: brush_ctrl
// PURPOSE
//  Consumes the debounced increase/decrease levels and 8-bit colour from the
//  debouncer and turns them into drawing state for the sketch pipeline.
//  Maintains a saturating brush-size register with press-to-step and
//  hold-to-auto-repeat. Registers the colour with a one-cycle change strobe.
//  Sits between the debouncer and the pixel/draw logic.
// PARAMETERS
//  SIZE_W        4           width of size output
//  SIZE_MIN      1           lowest size value; decrement saturates here
//  SIZE_MAX      15          highest size value; increment saturates here
//  SIZE_RESET    1           size after reset (SIZE_MIN<=SIZE_RESET<=SIZE_MAX)
//  HOLD_CYCLES   50_000_000  cycles from first step to first auto-repeat step
//  REPEAT_CYCLES 10_000_000  cycles between later auto-repeat steps
// PORTS
//  clk           in   1       system clock; all inputs are synchronous to it
//  rst           in   1       asynchronous, active-high reset
//  increase      in   1       debounced increase button level
//  decrease      in   1       debounced decrease button level
//  color         in   8       debounced switch colour
//  size          out  SIZE_W  current brush size
//  size_changed  out  1       1-cycle pulse when size takes a new value
//  color_out     out  8       registered colour
//  color_changed out  1       1-cycle pulse when color_out takes a new value
// BEHAVIOUR
//  - Reset (async, immediate): size=SIZE_RESET, size_changed=0, color_out=0,
//    color_changed=0, FSM=IDLE, timer=0. Previous-sample regs inc_q/dec_q=1,
//    so a button held across reset release causes no step.
//  - Rise = input 1 at this edge, 0 in inc_q/dec_q. Step occurs on that same
//    edge; size/size_changed are visible the following cycle (latency 1).
//  - Valid step: rise of one button while the other samples 0. Both high
//    together: no step.
//  - FSM IDLE: valid inc/dec rise -> step, latch dir, timer=0, go HOLD.
//  - HOLD: dir button low, or other button high -> IDLE, no step.
//    Otherwise timer++. When timer reaches HOLD_CYCLES-1 -> step, timer=0,
//    go REPEAT.
//  - REPEAT: same exit rule as HOLD. When timer reaches REPEAT_CYCLES-1 ->
//    step, timer=0.
//  - Step up: size<SIZE_MAX -> size+1, pulse size_changed. Else no change,
//    no pulse. Step down mirrors this with SIZE_MIN. No wrap-around.
//  - Timer width is $clog2(HOLD_CYCLES max REPEAT_CYCLES)+1 and never overflows.
//  - Colour: color_out<=color every cycle. color_changed=1 for one cycle when
//    the registered value differs from the previous color_out. No pulse on
//    the first cycle after reset unless color!=0.
//  - Colour path is independent of the size FSM. Both may pulse in the same cycle.
// CONFIGURATION
//  AUTOREPEAT_EN defined: HOLD/REPEAT states active as above.
//  AUTOREPEAT_EN undefined: FSM and timer removed. Exactly one step per valid
//    rise, however long the button is held. Same latency; HOLD_CYCLES and
//    REPEAT_CYCLES are ignored.
// TESTING (overrides: HOLD_CYCLES=8, REPEAT_CYCLES=4, AUTOREPEAT_EN defined)
//  1. rst pulse mid-operation with size=9 -> size=1, both strobes 0,
//     color_out=0x00 immediately, without waiting for a clk edge.
//  2. increase high 3 cycles, then low -> size 1->2 one cycle after first
//     high sample; exactly one size_changed pulse.
//  3. increase held 20 cycles from size=1 -> steps at cycles 0,8,12,16 ->
//     size=5; 4 pulses; release -> FSM IDLE.
//  4. size=14, three separate increase presses -> size=15 and one pulse.
//     size=1, one decrease press -> size stays 1, no pulse.
//  5. increase and decrease rise on the same edge -> no step. Hold increase,
//     raise decrease at cycle 3 -> no repeat step at cycle 8; size +1 only.
//  6. color 0x00->0xA5 -> color_out=0xA5 next cycle with one color_changed
//     pulse. Rebuild without AUTOREPEAT_EN and repeat scenario 3 -> size=2.

Source files
------------

// File: rtl/brush_ctrl.sv
// rtl/brush_ctrl.sv - brush size stepper with auto-repeat and registered colour strobe
//
// Purpose: turns debounced increase/decrease levels into a saturating brush
// size (press-to-step, hold-to-auto-repeat) and registers the switch colour
// with a one-cycle change strobe.
//
// Optional feature macro: AUTOREPEAT_EN
//   defined   - IDLE/HOLD/REPEAT FSM plus timer give hold-to-repeat stepping
//   undefined - exactly one step per valid rise; HOLD_CYCLES/REPEAT_CYCLES ignored
//
// Ports:
//   clk           in   1       system clock
//   rst           in   1       asynchronous active-high reset
//   increase      in   1       debounced increase button level
//   decrease      in   1       debounced decrease button level
//   color         in   8       debounced switch colour
//   size          out  SIZE_W  current brush size
//   size_changed  out  1       one-cycle pulse when size takes a new value
//   color_out     out  8       registered colour
//   color_changed out  1       one-cycle pulse when color_out takes a new value

module brush_ctrl #(
    parameter int SIZE_W        = 4,
    parameter int SIZE_MIN      = 1,
    parameter int SIZE_MAX      = 15,
    parameter int SIZE_RESET    = 1,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              increase,
    input  logic              decrease,
    input  logic [7:0]        color,
    output logic [SIZE_W-1:0] size,
    output logic              size_changed,
    output logic [7:0]        color_out,
    output logic              color_changed
);

    generate
        if (SIZE_MIN > SIZE_RESET || SIZE_RESET > SIZE_MAX ||
            HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
            $error("brush_ctrl: illegal parameter combination");
        end
    endgenerate

    localparam logic [SIZE_W-1:0] SMIN   = SIZE_W'(SIZE_MIN);
    localparam logic [SIZE_W-1:0] SMAX   = SIZE_W'(SIZE_MAX);
    localparam logic [SIZE_W-1:0] SRESET = SIZE_W'(SIZE_RESET);

    // Previous-sample registers reset to 1 so a button already held when
    // reset is released is not mistaken for a fresh press.
    logic inc_q;
    logic dec_q;
    logic valid_inc;
    logic valid_dec;
    logic step_up;
    logic step_dn;

    // A rise only counts while the opposite button is released.
    assign valid_inc = increase & ~inc_q & ~decrease;
    assign valid_dec = decrease & ~dec_q & ~increase;

`ifdef AUTOREPEAT_EN
    localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW   = $clog2(TMAX) + 1;
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_next;
    logic            dir;          // 1 = stepping up, 0 = stepping down
    logic            dir_next;
    logic            dir_btn;
    logic            other_btn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
            dir   <= 1'b0;
        end else begin
            state <= state_next;
            timer <= timer_next;
            dir   <= dir_next;
        end
    end

    always_comb begin
        state_next = state;
        timer_next = timer;
        dir_next   = dir;
        step_up    = 1'b0;
        step_dn    = 1'b0;
        dir_btn    = dir ? increase : decrease;
        other_btn  = dir ? decrease : increase;
        case (state)
            IDLE: begin
                if (valid_inc) begin
                    step_up    = 1'b1;
                    dir_next   = 1'b1;
                    timer_next = '0;
                    state_next = HOLD;
                end else if (valid_dec) begin
                    step_dn    = 1'b1;
                    dir_next   = 1'b0;
                    timer_next = '0;
                    state_next = HOLD;
                end
            end
            HOLD, REPEAT: begin
                // Releasing the held button or touching the other one ends
                // the repeat sequence without a step.
                if (!dir_btn || other_btn) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else if (timer == ((state == HOLD) ? HOLD_LAST : REP_LAST)) begin
                    step_up    = dir;
                    step_dn    = ~dir;
                    timer_next = '0;
                    state_next = REPEAT;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
    end
`else
    assign step_up = valid_inc;
    assign step_dn = valid_dec;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inc_q         <= 1'b1;
            dec_q         <= 1'b1;
            size          <= SRESET;
            size_changed  <= 1'b0;
            color_out     <= 8'h00;
            color_changed <= 1'b0;
        end else begin
            inc_q        <= increase;
            dec_q        <= decrease;
            size_changed <= 1'b0;
            if (step_up && size < SMAX) begin
                size         <= size + 1'b1;
                size_changed <= 1'b1;
            end else if (step_dn && size > SMIN) begin
                size         <= size - 1'b1;
                size_changed <= 1'b1;
            end
            color_out     <= color;
            color_changed <= (color != color_out);
        end
    end

endmodule

// File: tb/tb_brush_ctrl.sv
// tb/tb_brush_ctrl.sv - directed table-driven bench for brush_ctrl

module tb_brush_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       increase;
    logic       decrease;
    logic [7:0] color;
    logic [3:0] size;
    logic       size_changed;
    logic [7:0] color_out;
    logic       color_changed;

    always #5 clk = ~clk;

    brush_ctrl #(
        .SIZE_W(4),
        .SIZE_MIN(1),
        .SIZE_MAX(15),
        .SIZE_RESET(1),
        .HOLD_CYCLES(8),
        .REPEAT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .increase(increase),
        .decrease(decrease),
        .color(color),
        .size(size),
        .size_changed(size_changed),
        .color_out(color_out),
        .color_changed(color_changed)
    );

    typedef struct {
        logic       inc;
        logic       dec;
        logic [7:0] col;
        logic [3:0] e_size;
        logic       e_sc;
        logic [7:0] e_col;
        logic       e_cc;
    } vec_t;

    vec_t tbl[15];

    int n_cmp  = 0;
    int n_bad  = 0;
    int pulses = 0;
    logic [31:0] mask;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        if (size_changed) pulses++;
    endtask

    task automatic press_inc;
        increase = 1'b1;
        tick();
        increase = 1'b0;
        tick();
    endtask

    task automatic press_dec;
        decrease = 1'b1;
        tick();
        decrease = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 8'h00, 4'd1, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 8'h00, 4'd2, 1'b1, 8'h00, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 8'h00, 4'd2, 1'b0, 8'h00, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 8'h00, 4'd2, 1'b0, 8'h00, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 4'd2, 1'b0, 8'h00, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 8'hA5, 4'd2, 1'b0, 8'hA5, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 8'hA5, 4'd2, 1'b0, 8'hA5, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 8'hA5, 4'd2, 1'b0, 8'hA5, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 8'hA5, 4'd2, 1'b0, 8'hA5, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 8'hA5, 4'd1, 1'b1, 8'hA5, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 8'hA5, 4'd1, 1'b0, 8'hA5, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 8'hA5, 4'd1, 1'b0, 8'hA5, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 8'h3C, 4'd1, 1'b0, 8'h3C, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 8'hC3, 4'd2, 1'b1, 8'hC3, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 8'hC3, 4'd2, 1'b0, 8'hC3, 1'b0};

        rst      = 1'b1;
        increase = 1'b0;
        decrease = 1'b0;
        color    = 8'h00;
        tick();
        tick();
        chk("reset size", 32'(size), 32'd1);
        chk("reset size_changed", 32'(size_changed), 32'd0);
        chk("reset color_out", 32'(color_out), 32'h00);
        chk("reset color_changed", 32'(color_changed), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            increase = tbl[i].inc;
            decrease = tbl[i].dec;
            color    = tbl[i].col;
            tick();
            chk($sformatf("vec%0d size", i), 32'(size), 32'(tbl[i].e_size));
            chk($sformatf("vec%0d size_changed", i), 32'(size_changed), 32'(tbl[i].e_sc));
            chk($sformatf("vec%0d color_out", i), 32'(color_out), 32'(tbl[i].e_col));
            chk($sformatf("vec%0d color_changed", i), 32'(color_changed), 32'(tbl[i].e_cc));
        end

        // Long hold from size 1: repeat steps at cycles 0, 8, 12, 16.
        press_dec();
        chk("hold start size", 32'(size), 32'd1);
        pulses   = 0;
        mask     = '0;
        increase = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (size_changed) mask[k] = 1'b1;
        end
        increase = 1'b0;
        for (int k = 0; k < 10; k++) tick();
`ifdef AUTOREPEAT_EN
        chk("hold size", 32'(size), 32'd5);
        chk("hold pulses", 32'(pulses), 32'd4);
        chk("hold pulse cycles", mask, 32'h0001_1101);
`else
        chk("hold size", 32'(size), 32'd2);
        chk("hold pulses", 32'(pulses), 32'd1);
        chk("hold pulse cycles", mask, 32'h0000_0001);
`endif

        // Other button raised mid-hold cancels the pending repeat.
        for (int k = 0; k < 6; k++) press_dec();
        pulses   = 0;
        increase = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k == 3) decrease = 1'b1;
            tick();
        end
        increase = 1'b0;
        decrease = 1'b0;
        tick();
        tick();
        chk("cancel size", 32'(size), 32'd2);
        chk("cancel pulses", 32'(pulses), 32'd1);

        // Upper saturation.
        for (int k = 0; k < 12; k++) press_inc();
        chk("to 14 size", 32'(size), 32'd14);
        pulses = 0;
        for (int k = 0; k < 3; k++) press_inc();
        chk("sat max size", 32'(size), 32'd15);
        chk("sat max pulses", 32'(pulses), 32'd1);

        // Lower saturation.
        for (int k = 0; k < 14; k++) press_dec();
        chk("to 1 size", 32'(size), 32'd1);
        pulses = 0;
        press_dec();
        chk("sat min size", 32'(size), 32'd1);
        chk("sat min pulses", 32'(pulses), 32'd0);

        // Asynchronous reset mid-operation.
        for (int k = 0; k < 8; k++) press_inc();
        color = 8'h5A;
        tick();
        tick();
        chk("pre-rst size", 32'(size), 32'd9);
        chk("pre-rst color_out", 32'(color_out), 32'h5A);
        #3;
        rst = 1'b1;
        #1;
        chk("async rst size", 32'(size), 32'd1);
        chk("async rst size_changed", 32'(size_changed), 32'd0);
        chk("async rst color_out", 32'(color_out), 32'h00);
        chk("async rst color_changed", 32'(color_changed), 32'd0);

        // Button held across reset release must not step.
        color    = 8'h00;
        increase = 1'b1;
        tick();
        tick();
        rst    = 1'b0;
        pulses = 0;
        for (int k = 0; k < 4; k++) tick();
        chk("held over rst size", 32'(size), 32'd1);
        chk("held over rst pulses", 32'(pulses), 32'd0);
        increase = 1'b0;
        tick();
        press_inc();
        chk("post rst press size", 32'(size), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
